sync_up_count_mod: RTL and testbench



---
 rtl/sync_up_count_mod.sv | 75 +++++++
 tb/tb_sync_up_count_mod.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sync_up_count_mod.sv
// Synchronous modulo-MOD up counter with enable, clear, clamped parallel load,
// terminal-count / carry outputs and a sticky overflow flag.
// Count sequence is 0..MOD-1. With SATURATE=0 the count wraps to 0, and with
// SATURATE=1 it holds at MOD-1. Either way, an enabled edge at MOD-1 sets ovf.
// Stages cascade by wiring co of the lower stage to en of the upper stage.
// Both tc and co are combinational, so the upper stage steps on the same edge
// on which the lower stage wraps.
// rst must be applied before use; no power-up value is assumed.

module sync_up_count_mod #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             co,
    output logic             ovf
);

    // Last value in the sequence. The explicit compare against it is the only
    // wrap mechanism, so MOD = 2**WIDTH never depends on natural rollover.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic             WRAP    = ~SATURATE;

    logic             at_max;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;
    logic             ovf_next;

    assign at_max       = (count == MAX_VAL);
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    assign tc = at_max;
    assign co = at_max & en & WRAP;

    // Next-state selection. Priority is clr > load > en > hold; rst is applied in the register.
    always_comb begin
        count_next = count;
        ovf_next   = ovf;
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (load) begin
            count_next = load_clamped;
        end else if (en) begin
            if (at_max) begin
                ovf_next = 1'b1;
                if (WRAP) begin
                    count_next = '0;
                end
            end else begin
                count_next = count + WIDTH'(1);
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_sync_up_count_mod.sv
// Bench for sync_up_count_mod: three single-stage instances (16/wrap, 10/wrap,
// 10/saturate) share one stimulus stream. A two-digit decade cascade is run on
// its own afterwards.
module tb_sync_up_count_mod;

    logic       clk = 1'b0;
    logic       rst, en, clr, load;
    logic [3:0] load_val;
    logic [3:0] cnt_o [3];
    logic [2:0] tc_o, co_o, ovf_o;

    logic       rst_c, en_c;
    logic [3:0] cnt_lo, cnt_hi;
    logic       tc_lo, co_lo, ovf_lo, tc_hi, co_hi, ovf_hi;

    int n_total = 0;
    int n_bad   = 0;

    int  mods [3];
    bit  sats [3];
    int  m_cnt [3];
    bit  m_ovf [3];
    bit  armed = 1'b0;

    typedef struct {
        int cnt [3];
        bit ovf [3];
    } exp_t;
    exp_t sb [$];
    int   sb_cas [$];

    always #5 clk = ~clk;

    sync_up_count_mod #(.WIDTH(4), .MOD(16), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_o[0]), .tc(tc_o[0]), .co(co_o[0]), .ovf(ovf_o[0]));

    sync_up_count_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_o[1]), .tc(tc_o[1]), .co(co_o[1]), .ovf(ovf_o[1]));

    sync_up_count_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_o[2]), .tc(tc_o[2]), .co(co_o[2]), .ovf(ovf_o[2]));

    sync_up_count_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_lo (
        .clk(clk), .rst(rst_c), .en(en_c), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .count(cnt_lo), .tc(tc_lo), .co(co_lo), .ovf(ovf_lo));

    sync_up_count_mod #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_hi (
        .clk(clk), .rst(rst_c), .en(co_lo), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .count(cnt_hi), .tc(tc_hi), .co(co_hi), .ovf(ovf_hi));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of one counter stage for one clock edge.
    task automatic model_edge(input int idx, input bit r, input bit c, input bit l,
                              input int lv, input bit e);
        int top;
        top = mods[idx] - 1;
        if (r || c) begin
            m_cnt[idx] = 0;
            m_ovf[idx] = 1'b0;
        end else if (l) begin
            m_cnt[idx] = (lv > top) ? top : lv;
        end else if (e) begin
            if (m_cnt[idx] == top) begin
                m_ovf[idx] = 1'b1;
                if (!sats[idx]) m_cnt[idx] = 0;
            end else begin
                m_cnt[idx] = m_cnt[idx] + 1;
            end
        end
    endtask

    // Drive one cycle of stimulus, check the combinational outputs, then check the registered result.
    task automatic step(input bit r, input bit c, input bit l, input int lv, input bit e);
        exp_t x;
        bit   exp_tc;
        @(negedge clk);
        rst      = r;
        clr      = c;
        load     = l;
        load_val = 4'(lv);
        en       = e;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (armed) begin
                exp_tc = (m_cnt[i] == mods[i] - 1);
                chk($sformatf("tc%0d", i), 32'(tc_o[i]), 32'(exp_tc));
                chk($sformatf("co%0d", i), 32'(co_o[i]), 32'(exp_tc & e & !sats[i]));
            end
            model_edge(i, r, c, l, lv, e);
            x.cnt[i] = m_cnt[i];
            x.ovf[i] = m_ovf[i];
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count%0d", i), 32'(cnt_o[i]), 32'(x.cnt[i]));
            chk($sformatf("ovf%0d", i), 32'(ovf_o[i]), 32'(x.ovf[i]));
        end
        if (r) armed = 1'b1;
    endtask

    initial begin
        int exp_v;
        mods = '{16, 10, 10};
        sats = '{1'b0, 1'b0, 1'b1};
        m_cnt = '{0, 0, 0};
        m_ovf = '{1'b0, 1'b0, 1'b0};
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
        rst_c = 1'b1; en_c = 1'b0;

        // Reset, including a busy input pattern that rst must override.
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 9, 1);

        // Free run: 0..15,0,1 / wraps at 9 / holds at 9.
        for (int k = 0; k < 17; k++) step(0, 0, 0, 0, 1);

        // Clear pulse drops count and ovf.
        step(0, 1, 0, 0, 1);

        // Load has no increment; the next enabled edge increments.
        step(0, 0, 1, 7, 1);
        step(0, 0, 0, 0, 1);

        // Out-of-range load clamps to MOD-1 on the mod-10 stages.
        step(0, 0, 1, 12, 0);
        step(0, 0, 1, 15, 1);
        step(0, 0, 1, 9, 0);

        // clr beats load.
        step(0, 1, 1, 5, 1);

        // rst beats everything.
        step(0, 0, 1, 3, 0);
        step(1, 1, 1, 5, 1);

        // Enable gating at 5.
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // Reach 14 on the mod-16 stage, then rst with en high.
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Mixed random traffic.
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0);
        end

        // Two-digit decade cascade.
        @(negedge clk);
        en = 1'b0;
        rst_c = 1'b1;
        en_c  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_c = 1'b0;
        #1;
        chk("cas_reset", {24'd0, cnt_hi, cnt_lo}, 32'h00);
        chk("cas_ovf_reset", {30'd0, ovf_hi, ovf_lo}, 32'd0);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            en_c = 1'b1;
            exp_v = k % 100;
            sb_cas.push_back(exp_v);
            #1;
            chk("cas_co", 32'(co_lo), 32'((k - 1) % 10 == 9));
            @(posedge clk);
            #1;
            exp_v = sb_cas.pop_front();
            chk("cas_value", {24'd0, cnt_hi, cnt_lo}, 32'((exp_v / 10) * 16 + exp_v % 10));
        end
        @(negedge clk);
        en_c = 1'b0;
        #1;
        chk("cas_ovf_end", {30'd0, ovf_hi, ovf_lo}, 32'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
